branch_resolution_queue: RTL and testbench
==========================================

// Module: branch_resolution_queue
// PURPOSE
//  Parametrised successor branch resolver for the execute stage. Evaluates BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR at issue.
//  Holds up to DEPTH unresolved branches in order, each waiting for the PC of the instruction issued after it.
//  Emits predictor training results and a flush on target mismatch; reports misaligned-target exceptions.
// PARAMETERS
//  XLEN      32  data/PC width
//  DEPTH     2   max outstanding unresolved branches (power of 2, >=1)
//  ID_WIDTH  3   instruction id width
//  C_EXT     0   1: 2-byte instruction alignment, misaligned-target exception never raised
// PORTS
//  clk           in   1         clock
//  rst           in   1         synchronous, active-high reset
//  flush         in   1         external pipeline flush; clears queue
//  issue_valid   in   1         branch/jump issuing this cycle
//  issue_ready   out  1         queue can accept (count < DEPTH)
//  issue_id      in   ID_WIDTH  id of issuing branch
//  issue_kind    in   2         00 branch, 01 JALR, 11 JAL
//  issue_fn3     in   3         branch funct3
//  issue_pc      in   XLEN      PC of branch
//  issue_fallthru in  XLEN      PC of sequential next instruction
//  issue_offset  in   21        signed immediate (already shifted for JAL/branch)
//  issue_rs1     in   XLEN      rs1 value
//  issue_rs2     in   XLEN      rs2 value
//  next_valid    in   1         any instruction reached issue this cycle
//  next_pc       in   XLEN      its PC
//  res_valid     out  1         head branch resolved
//  res_id        out  ID_WIDTH  head id
//  res_pc        out  XLEN      head branch PC
//  res_target    out  XLEN      actual next PC
//  res_taken     out  1         taken (jumps always 1)
//  res_is_branch out  1         conditional branch
//  branch_flush  out  1         mispredict: fetch must redirect to res_target
//  exc_valid     out  1         misaligned target exception
//  exc_pc        out  XLEN      PC of faulting branch
//  exc_tval      out  XLEN      faulting target
// BEHAVIOUR
//  - Reset: count=0, head/tail=0; res_valid, branch_flush, exc_valid =0; exc_pc/exc_tval=0.
//  - Issue-cycle compute: signed compare unless fn3 in {BLTU,BGEU}; fn3[2] selects less-than, fn3[0] inverts.
//    taken = cond | (kind!=00). target = (JALR ? rs1 : pc) + sext(offset); JALR clears bit0.
//    next = taken ? target : issue_fallthru. All adds modulo 2^XLEN.
//  - Enqueue when issue_valid & issue_ready & ~branch_flush & ~flush & ~exc_trigger.
//  - Resolution (combinational): res_valid = count!=0 & next_valid; head must be enqueued in an earlier cycle.
//    Issue of a branch in the same cycle as next_valid resolves the previous head, not itself.
//  - branch_flush = res_valid & (next_pc[XLEN-1:1] != head.next[XLEN-1:1]); pops head, discards all younger entries.
//  - res_valid without flush: pop head only.
//  - Simultaneous enqueue+pop without flush: count unchanged; pointers wrap modulo DEPTH.
//  - exc_trigger (C_EXT=0 only): issue_valid & taken & target[1]. exc_valid registered, high 1 cycle later with
//    exc_pc/exc_tval captured; faulting entry not enqueued; queue cleared in the cycle exc_valid is high.
//  - flush input: queue cleared next edge; no res_valid/branch_flush suppression in that cycle.
//  - issue_ready = count<DEPTH (no same-cycle pop bypass).
//  - Reset mid-operation discards all entries; no outputs asserted the following cycle.
// TESTING
//  - BEQ pc=0x100, rs1=rs2=5, off=0x20; next_pc=0x120 -> res_valid, taken=1, target=0x120, branch_flush=0.
//  - BLT rs1=0xFFFFFFFF, rs2=1 (signed taken) vs BLTU same operands -> taken 1 vs 0; BLTU next_pc=0x120 -> flush, target=0x104.
//  - JALR rs1=0x2001, off=0 -> target=0x2000; next_pc=0x2000 -> no flush, res_is_branch=0.
//  - DEPTH=2: issue two branches back-to-back, third blocked (issue_ready=0); first mispredicts -> both discarded, count=0.
//  - C_EXT=0, JAL pc=0x100 off=0x2 -> exc_valid next cycle, exc_tval=0x102, exc_pc=0x100, no enqueue; C_EXT=1 -> no exception.
//  - Assert rst with 2 entries queued -> count=0, res_valid/exc_valid=0 next cycle even with next_valid=1.

Source files
------------

// File: rtl/branch_resolution_queue_if.sv
// Issue, resolution and exception signals between the execute stage and the branch resolver.
interface branch_resolution_queue_if #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned ID_WIDTH = 3
);
  logic                flush;
  logic                issue_valid;
  logic                issue_ready;
  logic [ID_WIDTH-1:0] issue_id;
  logic [1:0]          issue_kind;
  logic [2:0]          issue_fn3;
  logic [XLEN-1:0]     issue_pc;
  logic [XLEN-1:0]     issue_fallthru;
  logic [20:0]         issue_offset;
  logic [XLEN-1:0]     issue_rs1;
  logic [XLEN-1:0]     issue_rs2;
  logic                next_valid;
  logic [XLEN-1:0]     next_pc;
  logic                res_valid;
  logic [ID_WIDTH-1:0] res_id;
  logic [XLEN-1:0]     res_pc;
  logic [XLEN-1:0]     res_target;
  logic                res_taken;
  logic                res_is_branch;
  logic                branch_flush;
  logic                exc_valid;
  logic [XLEN-1:0]     exc_pc;
  logic [XLEN-1:0]     exc_tval;

  modport master (
    output flush, issue_valid, issue_id, issue_kind, issue_fn3, issue_pc, issue_fallthru,
           issue_offset, issue_rs1, issue_rs2, next_valid, next_pc,
    input  issue_ready, res_valid, res_id, res_pc, res_target, res_taken, res_is_branch,
           branch_flush, exc_valid, exc_pc, exc_tval
  );

  modport slave (
    input  flush, issue_valid, issue_id, issue_kind, issue_fn3, issue_pc, issue_fallthru,
           issue_offset, issue_rs1, issue_rs2, next_valid, next_pc,
    output issue_ready, res_valid, res_id, res_pc, res_target, res_taken, res_is_branch,
           branch_flush, exc_valid, exc_pc, exc_tval
  );
endinterface

// File: rtl/branch_resolution_queue.sv
// Resolves branches/jumps at issue and holds them in order until the following instruction's
// PC is seen, then reports training results and flushes on a wrong successor PC.
module branch_resolution_queue #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned ID_WIDTH = 3,
  parameter int unsigned C_EXT    = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  branch_resolution_queue_if.slave bus
);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     next;
    logic                taken;
    logic                is_branch;
  } entry_t;

  entry_t              mem_q [DEPTH];
  logic [PTR_W-1:0]    head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                exc_valid_q;
  logic [XLEN-1:0]     exc_pc_q, exc_tval_q;

  logic [XLEN-1:0]     off_sext, base, sum, target, next_addr;
  logic                is_jump, is_jalr, lt, cond, taken;
  logic                exc_trigger, enq, res_valid, br_flush, issue_ready;
  entry_t              head, new_entry;
  logic                unused_next_pc_lsb;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Issue-cycle evaluation of condition and target
  always_comb begin
    off_sext  = {{(XLEN-21){bus.issue_offset[20]}}, bus.issue_offset};
    is_jump   = (bus.issue_kind != 2'b00);
    is_jalr   = (bus.issue_kind == 2'b01);
    lt        = bus.issue_fn3[1] ? (bus.issue_rs1 < bus.issue_rs2)
                                 : ($signed(bus.issue_rs1) < $signed(bus.issue_rs2));
    cond      = (bus.issue_fn3[2] ? lt : (bus.issue_rs1 == bus.issue_rs2)) ^ bus.issue_fn3[0];
    taken     = cond | is_jump;
    base      = is_jalr ? bus.issue_rs1 : bus.issue_pc;
    sum       = base + off_sext;
    target    = is_jalr ? {sum[XLEN-1:1], 1'b0} : sum;
    next_addr = taken ? target : bus.issue_fallthru;
    new_entry = '{id: bus.issue_id, pc: bus.issue_pc, next: next_addr,
                  taken: taken, is_branch: ~is_jump};
  end

  // Head resolution against the successor PC; bit 0 never distinguishes a successor
  always_comb begin
    head        = mem_q[head_q];
    res_valid   = (count_q != '0) & bus.next_valid;
    br_flush    = res_valid & (bus.next_pc[XLEN-1:1] != head.next[XLEN-1:1]);
    issue_ready = (count_q < CNT_W'(DEPTH));
    exc_trigger = (C_EXT == 0) & bus.issue_valid & taken & target[1];
    enq         = bus.issue_valid & issue_ready & ~br_flush & ~bus.flush & ~exc_trigger;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (bus.flush | exc_valid_q | br_flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (enq)       tail_d = ptr_inc(tail_q);
      if (res_valid) head_d = ptr_inc(head_q);
      case ({enq, res_valid})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      exc_valid_q <= 1'b0;
      exc_pc_q    <= '0;
      exc_tval_q  <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      exc_valid_q <= exc_trigger;
      if (exc_trigger) begin
        exc_pc_q   <= bus.issue_pc;
        exc_tval_q <= target;
      end
    end
  end

  // Entry storage needs no reset; count_q qualifies every read
  always_ff @(posedge clk) begin
    if (enq) mem_q[tail_q] <= new_entry;
  end

  assign bus.issue_ready   = issue_ready;
  assign bus.res_valid     = res_valid;
  assign bus.res_id        = head.id;
  assign bus.res_pc        = head.pc;
  assign bus.res_target    = head.next;
  assign bus.res_taken     = head.taken;
  assign bus.res_is_branch = head.is_branch;
  assign bus.branch_flush  = br_flush;
  assign bus.exc_valid     = exc_valid_q;
  assign bus.exc_pc        = exc_pc_q;
  assign bus.exc_tval      = exc_tval_q;

  assign unused_next_pc_lsb = bus.next_pc[0];
endmodule

// File: tb/tb_branch_resolution_queue.sv
// Directed bench for branch_resolution_queue: main instance C_EXT=0, shadow instance C_EXT=1.
module tb_branch_resolution_queue;
  localparam int unsigned XLEN = 32;
  localparam int unsigned IDW  = 3;

  logic clk;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  branch_resolution_queue_if #(.XLEN(XLEN), .ID_WIDTH(IDW)) bus   ();
  branch_resolution_queue_if #(.XLEN(XLEN), .ID_WIDTH(IDW)) bus_c ();

  branch_resolution_queue #(.XLEN(XLEN), .DEPTH(2), .ID_WIDTH(IDW), .C_EXT(0)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  branch_resolution_queue #(.XLEN(XLEN), .DEPTH(2), .ID_WIDTH(IDW), .C_EXT(1)) u_dut_c (
    .clk (clk),
    .rst (rst),
    .bus (bus_c.slave)
  );

  // Shadow instance sees identical stimulus
  assign bus_c.flush          = bus.flush;
  assign bus_c.issue_valid    = bus.issue_valid;
  assign bus_c.issue_id       = bus.issue_id;
  assign bus_c.issue_kind     = bus.issue_kind;
  assign bus_c.issue_fn3      = bus.issue_fn3;
  assign bus_c.issue_pc       = bus.issue_pc;
  assign bus_c.issue_fallthru = bus.issue_fallthru;
  assign bus_c.issue_offset   = bus.issue_offset;
  assign bus_c.issue_rs1      = bus.issue_rs1;
  assign bus_c.issue_rs2      = bus.issue_rs2;
  assign bus_c.next_valid     = bus.next_valid;
  assign bus_c.next_pc        = bus.next_pc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.flush          = 1'b0;
    bus.issue_valid    = 1'b0;
    bus.issue_id       = '0;
    bus.issue_kind     = 2'b00;
    bus.issue_fn3      = 3'b000;
    bus.issue_pc       = '0;
    bus.issue_fallthru = '0;
    bus.issue_offset   = '0;
    bus.issue_rs1      = '0;
    bus.issue_rs2      = '0;
    bus.next_valid     = 1'b0;
    bus.next_pc        = '0;
  endtask

  task automatic drive_issue(input logic [IDW-1:0] id, input logic [1:0] kind, input logic [2:0] fn3,
                             input logic [31:0] pc, input logic [31:0] fall, input logic [20:0] off,
                             input logic [31:0] rs1, input logic [31:0] rs2);
    bus.issue_valid    = 1'b1;
    bus.issue_id       = id;
    bus.issue_kind     = kind;
    bus.issue_fn3      = fn3;
    bus.issue_pc       = pc;
    bus.issue_fallthru = fall;
    bus.issue_offset   = off;
    bus.issue_rs1      = rs1;
    bus.issue_rs2      = rs2;
  endtask

  task automatic resolve(input logic [31:0] npc);
    bus.issue_valid = 1'b0;
    bus.next_valid  = 1'b1;
    bus.next_pc     = npc;
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("rst_ready", bus.issue_ready, 1);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_exc_valid", bus.exc_valid, 0);
    check("rst_exc_pc", bus.exc_pc, 0);
    check("rst_exc_tval", bus.exc_tval, 0);
    step();

    // BEQ taken, predicted successor correct
    drive_issue(3'd1, 2'b00, 3'b000, 32'h100, 32'h104, 21'h20, 32'd5, 32'd5);
    #1;
    check("beq_no_self_res", bus.res_valid, 0);
    step();
    resolve(32'h120);
    check("beq_valid", bus.res_valid, 1);
    check("beq_id", bus.res_id, 1);
    check("beq_pc", bus.res_pc, 32'h100);
    check("beq_taken", bus.res_taken, 1);
    check("beq_target", bus.res_target, 32'h120);
    check("beq_flush", bus.branch_flush, 0);
    check("beq_is_branch", bus.res_is_branch, 1);
    step();
    bus.next_pc = 32'h124;
    #1;
    check("beq_popped", bus.res_valid, 0);
    step();

    // BLT signed: -1 < 1 taken
    bus.next_valid = 1'b0;
    drive_issue(3'd2, 2'b00, 3'b100, 32'h100, 32'h104, 21'h20, 32'hFFFF_FFFF, 32'd1);
    step();
    resolve(32'h120);
    check("blt_taken", bus.res_taken, 1);
    check("blt_flush", bus.branch_flush, 0);
    step();

    // BLTU: 0xFFFFFFFF < 1 false, successor 0x120 is wrong
    bus.next_valid = 1'b0;
    drive_issue(3'd3, 2'b00, 3'b110, 32'h100, 32'h104, 21'h20, 32'hFFFF_FFFF, 32'd1);
    step();
    resolve(32'h120);
    check("bltu_valid", bus.res_valid, 1);
    check("bltu_taken", bus.res_taken, 0);
    check("bltu_flush", bus.branch_flush, 1);
    check("bltu_target", bus.res_target, 32'h104);
    step();

    // JALR clears bit 0 of the target
    bus.next_valid = 1'b0;
    drive_issue(3'd4, 2'b01, 3'b000, 32'h300, 32'h304, 21'h0, 32'h2001, 32'd0);
    step();
    resolve(32'h2000);
    check("jalr_target", bus.res_target, 32'h2000);
    check("jalr_flush", bus.branch_flush, 0);
    check("jalr_is_branch", bus.res_is_branch, 0);
    check("jalr_taken", bus.res_taken, 1);
    step();

    // Issue in the same cycle as next_valid resolves the older head, not itself
    bus.next_valid = 1'b0;
    drive_issue(3'd5, 2'b00, 3'b000, 32'h500, 32'h504, 21'h40, 32'd7, 32'd7);
    step();
    drive_issue(3'd6, 2'b11, 3'b000, 32'h540, 32'h544, 21'h100, 32'd0, 32'd0);
    bus.next_valid = 1'b1;
    bus.next_pc    = 32'h540;
    #1;
    check("same_cyc_id", bus.res_id, 5);
    check("same_cyc_flush", bus.branch_flush, 0);
    step();
    resolve(32'h640);
    check("jal_id", bus.res_id, 6);
    check("jal_target", bus.res_target, 32'h640);
    check("jal_flush", bus.branch_flush, 0);
    step();

    // Fill DEPTH=2, third blocked, first mispredicts and discards both
    bus.next_valid = 1'b0;
    drive_issue(3'd2, 2'b00, 3'b000, 32'h400, 32'h404, 21'h10, 32'd1, 32'd2);
    step();
    drive_issue(3'd3, 2'b00, 3'b001, 32'h404, 32'h408, 21'h10, 32'd1, 32'd2);
    step();
    drive_issue(3'd7, 2'b00, 3'b000, 32'h414, 32'h418, 21'h10, 32'd0, 32'd0);
    #1;
    check("full_ready", bus.issue_ready, 0);
    step();
    resolve(32'h500);
    check("full_head_id", bus.res_id, 2);
    check("full_flush", bus.branch_flush, 1);
    check("full_target", bus.res_target, 32'h404);
    step();
    resolve(32'h404);
    check("full_cleared", bus.res_valid, 0);
    check("full_ready_after", bus.issue_ready, 1);
    step();

    // External flush: resolution still visible that cycle, queue empty afterwards
    bus.next_valid = 1'b0;
    drive_issue(3'd1, 2'b00, 3'b000, 32'h100, 32'h104, 21'h20, 32'd5, 32'd5);
    step();
    bus.flush = 1'b1;
    resolve(32'h120);
    check("flush_cycle_res", bus.res_valid, 1);
    step();
    bus.flush = 1'b0;
    resolve(32'h120);
    check("flush_cleared", bus.res_valid, 0);
    step();

    // Misaligned JAL target
    bus.next_valid = 1'b0;
    drive_issue(3'd1, 2'b11, 3'b000, 32'h100, 32'h104, 21'h2, 32'd0, 32'd0);
    #1;
    check("exc_not_yet", bus.exc_valid, 0);
    step();
    bus.issue_valid = 1'b0;
    #1;
    check("exc_valid", bus.exc_valid, 1);
    check("exc_pc", bus.exc_pc, 32'h100);
    check("exc_tval", bus.exc_tval, 32'h102);
    check("exc_cext_none", bus_c.exc_valid, 0);
    resolve(32'h102);
    check("exc_not_enq", bus.res_valid, 0);
    step();
    bus.next_valid = 1'b0;
    #1;
    check("exc_one_cycle", bus.exc_valid, 0);
    step();

    // Exception clears an older queued entry
    drive_issue(3'd1, 2'b00, 3'b000, 32'h100, 32'h104, 21'h20, 32'd5, 32'd5);
    step();
    drive_issue(3'd2, 2'b11, 3'b000, 32'h120, 32'h124, 21'h2, 32'd0, 32'd0);
    step();
    bus.issue_valid = 1'b0;
    #1;
    check("exc2_valid", bus.exc_valid, 1);
    step();
    resolve(32'h120);
    check("exc2_cleared", bus.res_valid, 0);
    step();

    // Reset with two entries queued and a misaligned issue pending
    bus.next_valid = 1'b0;
    drive_issue(3'd1, 2'b00, 3'b000, 32'h100, 32'h104, 21'h20, 32'd5, 32'd5);
    step();
    drive_issue(3'd2, 2'b00, 3'b000, 32'h120, 32'h124, 21'h20, 32'd5, 32'd5);
    step();
    rst = 1'b1;
    drive_issue(3'd3, 2'b11, 3'b000, 32'h200, 32'h204, 21'h2, 32'd0, 32'd0);
    bus.next_valid = 1'b1;
    bus.next_pc    = 32'h120;
    step();
    rst = 1'b0;
    resolve(32'h120);
    check("rst2_res_valid", bus.res_valid, 0);
    check("rst2_exc_valid", bus.exc_valid, 0);
    check("rst2_flush", bus.branch_flush, 0);
    check("rst2_ready", bus.issue_ready, 1);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
